otter_rf_writeback: RTL and testbench

- Write-side front end for the OTTER register file. It merges the in-order pipeline writeback (port A) and a long-latency unit such as mul/div or a load miss (port B, valid/ready) onto the single register-file write port.
- It keeps a 32-entry busy scoreboard of destination registers owned by in-flight long-latency ops. The decode stage uses it for RAW/WAW stalls.
- It sits between the writeback stage, the long-latency unit, and the register-file write inputs (RegWrite/WriteReg/WriteData).

---
 rtl/otter_rf_pkg.sv | 26 ++
 rtl/otter_wb_fifo.sv | 59 +++++
 rtl/otter_rf_writeback.sv | 147 ++++++++++++++
 tb/tb_otter_rf_writeback.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/otter_rf_pkg.sv
// otter_rf_pkg
// Shared types for the OTTER register-file writeback front end:
//   NUM_REGS    - architectural register count
//   reg_idx_t   - register index
//   word_t      - data word
//   wb_entry_t  - queued long-latency result (destination + data)
//   wb_state_t  - writeback arbiter state
package otter_rf_pkg;

    localparam int NUM_REGS = 32;

    typedef logic [4:0]  reg_idx_t;
    typedef logic [31:0] word_t;

    typedef struct packed {
        reg_idx_t rd;
        word_t    data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        FORCE = 2'd2
    } wb_state_t;

endpackage

// File: rtl/otter_wb_fifo.sv
// otter_wb_fifo
// Synchronous FIFO of wb_entry_t holding long-latency results until they
// win the register-file write port.
// Ports:
//   clock, reset_n   - clock, async active-low reset (empties the FIFO)
//   push, wdata      - enqueue (ignored when full)
//   pop              - dequeue head (ignored when empty)
//   rdata            - current head entry
//   full, empty      - status from pointer compare
//   count            - occupancy
module otter_wb_fifo
    import otter_rf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  wb_entry_t                wdata,
    input  logic                     pop,
    output wb_entry_t                rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    // One extra wrap bit distinguishes full from empty when the indices match.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    wb_entry_t   mem [DEPTH];

    logic do_push;
    logic do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign count   = wr_ptr - rd_ptr;
    assign rdata   = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/otter_rf_writeback.sv
// otter_rf_writeback
// Merges the in-order pipeline writeback (A) and a long-latency result
// stream (B, valid/ready through a FIFO) onto the single register-file
// write port, and tracks registers owned by in-flight long-latency ops.
// Ports:
//   clock, reset_n                 - clock, async active-low reset
//   a_valid, a_rd, a_data, a_stall - pipeline writeback; a_stall asks the
//                                    pipeline to hold A for one cycle
//   b_valid, b_ready, b_rd, b_data - long-latency result handshake
//   iss_valid, iss_rd              - long-latency issue, marks rd busy
//   q_rs1, q_rs2, q_rd, hazard     - decode hazard query
//   rf_we, rf_waddr, rf_wdata      - register-file write port
//   err                            - sticky protocol-violation flag
module otter_rf_writeback
    import otter_rf_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        a_valid,
    input  logic [4:0]  a_rd,
    input  logic [31:0] a_data,
    output logic        a_stall,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_rd,
    input  logic [31:0] b_data,
    input  logic        iss_valid,
    input  logic [4:0]  iss_rd,
    input  logic [4:0]  q_rs1,
    input  logic [4:0]  q_rs2,
    input  logic [4:0]  q_rd,
    output logic        hazard,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STARVE_LIMIT - 1);

    wb_state_t            state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [NUM_REGS-1:0]  busy, busy_n;
    logic                 err_n;

    wb_entry_t            head;
    logic                 full, empty;
    logic [AW:0]          count, count_n;

    logic a_eff, push, pop, blocked, iss_set;

    // a_stall comes straight off the state register.
    assign a_stall = (state == FORCE);
    assign a_eff   = a_valid && (a_rd != 5'd0) && !a_stall;
    assign b_ready = reset_n && !full;
    assign push    = b_valid && b_ready;
    // In FORCE a_eff is low, so the head always goes through.
    assign pop     = !empty && !a_eff;
    assign blocked = (state == PEND) && !empty && a_eff;
    assign iss_set = iss_valid && (iss_rd != 5'd0);
    assign hazard  = busy[q_rs1] | busy[q_rs2] | busy[q_rd];
    assign count_n = count + (AW+1)'(push) - (AW+1)'(pop);

    otter_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push),
        .wdata   ('{rd: b_rd, data: b_data}),
        .pop     (pop),
        .rdata   (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    // Write port: A has priority, otherwise the FIFO head; an x0 head pops silently.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'd0;
        if (a_eff) begin
            rf_we    = 1'b1;
            rf_waddr = a_rd;
            rf_wdata = a_data;
        end else if (pop && (head.rd != 5'd0)) begin
            rf_we    = 1'b1;
            rf_waddr = head.rd;
            rf_wdata = head.data;
        end
        if (!reset_n) rf_we = 1'b0;
    end

    // Arbiter: count consecutive losses of the head; the loss after the
    // counter hits its last value forces one B-only cycle.
    always_comb begin
        cnt_n = cnt;
        if (pop)
            cnt_n = '0;
        else if (blocked && (cnt != CNT_LAST))
            cnt_n = cnt + CW'(1);

        if (blocked && (cnt == CNT_LAST))
            state_n = FORCE;
        else if (count_n == '0)
            state_n = IDLE;
        else
            state_n = PEND;
    end

    // Scoreboard: a set on the same rd as a commit clear wins.
    always_comb begin
        busy_n = busy;
        if (pop)     busy_n[head.rd] = 1'b0;
        if (iss_set) busy_n[iss_rd]  = 1'b1;
        busy_n[0] = 1'b0;
    end

    always_comb begin
        err_n = err;
        if (iss_set && busy[iss_rd] && !(pop && (head.rd == iss_rd)))
            err_n = 1'b1;
        if (a_eff && busy[a_rd])
            err_n = 1'b1;
        if (pop && (head.rd != 5'd0) && !busy[head.rd])
            err_n = 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            busy  <= busy_n;
            err   <= err_n;
        end
    end

endmodule

// File: tb/tb_otter_rf_writeback.sv
// tb_otter_rf_writeback
// Directed self-checking bench for otter_rf_writeback (FIFO_DEPTH=4,
// STARVE_LIMIT=8). Inputs change 1ns after posedge, outputs are checked
// 1ns later, well away from the active edge.
module tb_otter_rf_writeback;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        a_valid;
    logic [4:0]  a_rd;
    logic [31:0] a_data;
    logic        a_stall;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_rd;
    logic [31:0] b_data;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  q_rs1, q_rs2, q_rd;
    logic        hazard;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    otter_rf_writeback #(.FIFO_DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .a_valid   (a_valid),
        .a_rd      (a_rd),
        .a_data    (a_data),
        .a_stall   (a_stall),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_rd      (b_rd),
        .b_data    (b_data),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .q_rs1     (q_rs1),
        .q_rs2     (q_rs2),
        .q_rd      (q_rd),
        .hazard    (hazard),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .err       (err)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        a_valid = 0; a_rd = 0; a_data = 0;
        b_valid = 0; b_rd = 0; b_data = 0;
        iss_valid = 0; iss_rd = 0;
        q_rs1 = 0; q_rs2 = 0; q_rd = 0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle_inputs();
        #1;
        n_cmp++;
        if ({rf_we, b_ready, hazard, a_stall, err} !== 5'b00000) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b want 00000", {rf_we, b_ready, hazard, a_stall, err});
        end
        tick(); tick();
        reset_n = 1'b1;
        #1;
        n_cmp++;
        if ({rf_we, b_ready, a_stall} !== 3'b010) begin
            n_bad++;
            $display("FAIL reset_release: got %b want 010", {rf_we, b_ready, a_stall});
        end
        tick();
    endtask

    task automatic test_basic_b();
        idle_inputs();
        iss_valid = 1; iss_rd = 5;
        tick();
        idle_inputs();
        q_rs1 = 5;
        b_valid = 1; b_rd = 5; b_data = 32'hDEADBEEF;
        #1;
        n_cmp++;
        if ({hazard, rf_we} !== 2'b10) begin
            n_bad++;
            $display("FAIL basic_busy_no_passthru: got %b want 10", {hazard, rf_we});
        end
        tick();
        b_valid = 0;
        #1;
        n_cmp++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
            n_bad++;
            $display("FAIL basic_b_write: got %b/%0d/%h want 1/5/deadbeef", rf_we, rf_waddr, rf_wdata);
        end
        tick();
        n_cmp++;
        if ({hazard, rf_we} !== 2'b00) begin
            n_bad++;
            $display("FAIL basic_hazard_clear: got %b want 00", {hazard, rf_we});
        end
    endtask

    task automatic test_priority();
        idle_inputs();
        iss_valid = 1; iss_rd = 9;
        b_valid = 1; b_rd = 9; b_data = 32'h99;
        tick();
        idle_inputs();
        a_valid = 1; a_rd = 7; a_data = 32'h11;
        #1;
        n_cmp++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd7, 32'h11}) begin
            n_bad++;
            $display("FAIL prio_a_first: got %b/%0d/%h want 1/7/11", rf_we, rf_waddr, rf_wdata);
        end
        tick();
        a_valid = 0;
        #1;
        n_cmp++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd9, 32'h99}) begin
            n_bad++;
            $display("FAIL prio_b_after: got %b/%0d/%h want 1/9/99", rf_we, rf_waddr, rf_wdata);
        end
        tick();
        n_cmp++;
        if ({rf_we, err} !== 2'b00) begin
            n_bad++;
            $display("FAIL prio_drained: got %b want 00", {rf_we, err});
        end
    endtask

    task automatic test_starvation();
        idle_inputs();
        iss_valid = 1; iss_rd = 12;
        b_valid = 1; b_rd = 12; b_data = 32'hC0FFEE;
        tick();
        idle_inputs();
        for (int k = 1; k <= 8; k++) begin
            a_valid = 1; a_rd = 5'(20 + k); a_data = 32'h100 + k;
            #1;
            n_cmp++;
            if ({a_stall, rf_we, rf_waddr} !== {1'b0, 1'b1, 5'(20 + k)}) begin
                n_bad++;
                $display("FAIL starve_a_wins[%0d]: got %b/%b/%0d want 0/1/%0d", k, a_stall, rf_we, rf_waddr, 20 + k);
            end
            tick();
        end
        a_valid = 1; a_rd = 29; a_data = 32'h109;
        #1;
        n_cmp++;
        if ({a_stall, rf_we, rf_waddr, rf_wdata} !== {1'b1, 1'b1, 5'd12, 32'hC0FFEE}) begin
            n_bad++;
            $display("FAIL starve_force: got %b/%b/%0d/%h want 1/1/12/c0ffee", a_stall, rf_we, rf_waddr, rf_wdata);
        end
        tick();
        // pipeline held A during the stall cycle
        #1;
        n_cmp++;
        if ({a_stall, rf_we, rf_waddr, rf_wdata} !== {1'b0, 1'b1, 5'd29, 32'h109}) begin
            n_bad++;
            $display("FAIL starve_a_held: got %b/%b/%0d/%h want 0/1/29/109", a_stall, rf_we, rf_waddr, rf_wdata);
        end
        tick();
        a_valid = 0;
        #1;
        n_cmp++;
        if ({rf_we, err} !== 2'b00) begin
            n_bad++;
            $display("FAIL starve_after: got %b want 00", {rf_we, err});
        end
        tick();
    endtask

    task automatic test_full();
        int i_push = 0;
        int i_pop = 0;
        idle_inputs();
        for (int c = 0; c < 40; c++) begin
            a_valid = (c < 5); a_rd = 1; a_data = c;
            b_valid = (i_push < 10);
            b_rd = 5'(10 + i_push); b_data = 32'hA00 + i_push;
            iss_valid = b_valid && b_ready; iss_rd = b_rd;
            #1;
            if (c == 4 || c == 5) begin
                n_cmp++;
                if (b_ready !== 1'b0) begin
                    n_bad++;
                    $display("FAIL full_ready_low[c%0d]: got %b want 0", c, b_ready);
                end
            end
            if (c == 6) begin
                n_cmp++;
                if (b_ready !== 1'b1) begin
                    n_bad++;
                    $display("FAIL full_ready_back: got %b want 1", b_ready);
                end
            end
            if (c < 5) begin
                n_cmp++;
                if ({rf_we, rf_waddr} !== {1'b1, 5'd1}) begin
                    n_bad++;
                    $display("FAIL full_a_write[c%0d]: got %b/%0d want 1/1", c, rf_we, rf_waddr);
                end
            end else if (rf_we) begin
                n_cmp++;
                if ({rf_waddr, rf_wdata} !== {5'(10 + i_pop), 32'hA00 + i_pop}) begin
                    n_bad++;
                    $display("FAIL full_order[%0d]: got %0d/%h want %0d/%h", i_pop, rf_waddr, rf_wdata, 10 + i_pop, 32'hA00 + i_pop);
                end
                i_pop++;
            end
            if (b_valid && b_ready) i_push++;
            tick();
        end
        n_cmp++;
        if ({i_push, i_pop, 31'd0, err} !== {32'd10, 32'd10, 32'd0}) begin
            n_bad++;
            $display("FAIL full_counts: pushed %0d popped %0d err %b want 10/10/0", i_push, i_pop, err);
        end
    endtask

    task automatic test_reset_midop();
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            a_valid = 1; a_rd = 2; a_data = k;
            iss_valid = 1; iss_rd = 5'(4 + 2 * k);
            b_valid = 1; b_rd = 5'(4 + 2 * k); b_data = 32'hF0 + k;
            tick();
        end
        iss_valid = 0; b_valid = 0;
        q_rs1 = 6;
        #1;
        n_cmp++;
        if (hazard !== 1'b1) begin
            n_bad++;
            $display("FAIL midop_busy: got %b want 1", hazard);
        end
        #1;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({rf_we, b_ready, hazard} !== 3'b000) begin
            n_bad++;
            $display("FAIL midop_async: got %b want 000", {rf_we, b_ready, hazard});
        end
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        idle_inputs();
        iss_valid = 1; iss_rd = 4;
        b_valid = 1; b_rd = 4; b_data = 32'h44;
        #1;
        n_cmp++;
        if ({rf_we, b_ready, a_stall, err} !== 4'b0100) begin
            n_bad++;
            $display("FAIL midop_release: got %b want 0100", {rf_we, b_ready, a_stall, err});
        end
        tick();
        idle_inputs();
        #1;
        n_cmp++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd4, 32'h44}) begin
            n_bad++;
            $display("FAIL midop_fresh_entry: got %b/%0d/%h want 1/4/44", rf_we, rf_waddr, rf_wdata);
        end
        tick();
        n_cmp++;
        if ({rf_we, err} !== 2'b00) begin
            n_bad++;
            $display("FAIL midop_fifo_empty: got %b want 00", {rf_we, err});
        end
    endtask

    task automatic test_err_x0();
        idle_inputs();
        a_valid = 1; a_rd = 0; a_data = 32'h55;
        iss_valid = 1; iss_rd = 0;
        #1;
        n_cmp++;
        if (rf_we !== 1'b0) begin
            n_bad++;
            $display("FAIL x0_a_ignored: got %b want 0", rf_we);
        end
        tick();
        idle_inputs();
        iss_valid = 1; iss_rd = 3;
        #1;
        n_cmp++;
        if ({hazard, err} !== 2'b00) begin
            n_bad++;
            $display("FAIL x0_not_busy: got %b want 00", {hazard, err});
        end
        tick();
        q_rd = 3;
        #1;
        n_cmp++;
        if ({hazard, err} !== 2'b10) begin
            n_bad++;
            $display("FAIL err_before_reiss: got %b want 10", {hazard, err});
        end
        tick();
        iss_valid = 0;
        #1;
        n_cmp++;
        if (err !== 1'b1) begin
            n_bad++;
            $display("FAIL err_set: got %b want 1", err);
        end
        tick(); tick(); tick();
        n_cmp++;
        if (err !== 1'b1) begin
            n_bad++;
            $display("FAIL err_sticky: got %b want 1", err);
        end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({err, hazard} !== 2'b00) begin
            n_bad++;
            $display("FAIL err_reset: got %b want 00", {err, hazard});
        end
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_b();
        test_priority();
        test_starvation();
        test_full();
        test_reset_midop();
        test_err_x0();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
